// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Fetch entries carry {pc, inst, fault} from the fetch FIFO to decode.
package fetch_unit_pkg;

    localparam int ADDR_W = 64;
    localparam int INST_W = 32;
    localparam logic [ADDR_W-1:0] PC_RST = 64'h8000_0000;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALTED
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush.
// The head entry is driven straight from storage, so no input-to-output path.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     pushData,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] cnt;
    logic             doPop;
    logic             full;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign doPop = pop && (cnt != '0);
    assign full  = (cnt == CNT_W'(DEPTH));
    assign head  = mem[rdPtr];
    assign count = cnt;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else begin
            if (push) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (doPop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            if (push && !doPop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!push && doPop) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Credits upstream must keep a push away from a full FIFO.
    a_noOverflow: assert property (
        @(posedge clk) disable iff (!rst) !(push && !flush && full && !doPop)
    );

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credited word reads,
// buffers responses and hands {pc, inst, fault} to decode.
module fetch_unit #(
    parameter int                ADDR_W = fetch_unit_pkg::ADDR_W,
    parameter int                INST_W = fetch_unit_pkg::INST_W,
    parameter logic [ADDR_W-1:0] PC_RST = fetch_unit_pkg::PC_RST,
    parameter int                DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_fault
);

    import fetch_unit_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e     state;
    fetch_state_e     stateNext;
    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] rspPc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] inflightNext;
    logic [CNT_W-1:0] stale;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W:0]   credUsed;
    logic             reqFire;
    logic             push;
    logic             pop;
    fetch_entry_t     pushEntry;
    fetch_entry_t     head;

    assign credUsed = {1'b0, occupancy} + {1'b0, inflight};

    assign imem_req_valid = rst && (state == FETCH_RUN) && !redirect_valid
                            && (credUsed < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = fetchPc;
    assign reqFire        = imem_req_valid && imem_req_ready;

    // Only live responses reach the FIFO; halted or stale words are dropped.
    assign push = imem_rsp_valid && (stale == '0) && (state == FETCH_RUN)
                  && !redirect_valid;
    assign pop  = (occupancy != '0) && out_ready && !redirect_valid;

    assign inflightNext = inflight + CNT_W'(reqFire) - CNT_W'(imem_rsp_valid);

    always_comb begin
        pushEntry       = '0;
        pushEntry.pc    = rspPc;
        pushEntry.inst  = imem_rsp_err ? '0 : imem_rsp_data;
        pushEntry.fault = imem_rsp_err;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (push),
        .pushData (pushEntry),
        .pop      (pop),
        .head     (head),
        .count    (occupancy)
    );

    always_comb begin
        stateNext = state;
        if (redirect_valid) begin
            stateNext = FETCH_RUN;
        end else if (push && imem_rsp_err) begin
            stateNext = FETCH_HALTED;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH_RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc  <= PC_RST;
            rspPc    <= PC_RST;
            inflight <= '0;
            stale    <= '0;
        end else if (redirect_valid) begin
            fetchPc  <= redirect_pc;
            rspPc    <= redirect_pc;
            inflight <= inflightNext;
            stale    <= inflightNext;
        end else begin
            if (reqFire) begin
                fetchPc <= fetchPc + ADDR_W'(4);
            end
            if (push) begin
                rspPc <= rspPc + ADDR_W'(4);
            end
            inflight <= inflightNext;
            if (imem_rsp_valid && (stale != '0)) begin
                stale <= stale - CNT_W'(1);
            end
        end
    end

    assign out_valid = (occupancy != '0);
    assign out_pc    = out_valid ? head.pc : '0;
    assign out_inst  = out_valid ? head.inst : '0;
    assign out_fault = out_valid && head.fault;

    a_redirAligned: assert property (
        @(posedge clk) disable iff (!rst)
        redirect_valid |-> (redirect_pc[1:0] == 2'b00)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a PC-stream reference model.
// The bench plays instruction memory: in-order responses with random latency.
module tb_fetch_unit;

    localparam logic [63:0] PC0   = 64'h8000_0000;
    localparam int          DEPTH = 2;
    localparam logic [63:0] NOFLT = 64'hFFFF_FFFF_FFFF_FFF0;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;

    int total = 0;
    int bad   = 0;

    logic [63:0] memQ [$];
    logic [63:0] expReq;
    logic [63:0] expOut;
    logic [63:0] faultAddr;
    bit          halted;
    int          pending;
    int          outCnt;
    int          rdyPct;
    int          rspPct;
    int          outPct;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_fault      (out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset(input logic [63:0] pc);
        expReq  = pc;
        expOut  = pc;
        halted  = 1'b0;
        pending = 0;
    endtask

    task automatic idleInputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
    endtask

    task automatic cycle(input bit redir, input logic [63:0] rpc);
        logic [63:0] a;
        bit          expFault;
        @(negedge clk);
        imem_req_ready = ($urandom_range(99) < rdyPct);
        if (memQ.size() != 0 && $urandom_range(99) < rspPct) begin
            a = memQ.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(a);
            imem_rsp_err   = (a == faultAddr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            imem_rsp_err   = 1'($urandom_range(1));
        end
        out_ready      = ($urandom_range(99) < outPct);
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        if (redir) chk("redirNoReq", imem_req_valid, 0);
        if (halted && !redir) begin
            chk("haltReq", imem_req_valid, 0);
            chk("haltOut", out_valid, 0);
        end
        if (imem_req_valid && imem_req_ready) begin
            chk("reqAddr", imem_req_addr, expReq);
            expReq += 4;
            memQ.push_back(imem_req_addr);
            pending++;
            chk("credit", pending <= DEPTH, 1);
        end
        if (redir) begin
            modelReset(rpc);
        end else if (out_valid && out_ready) begin
            expFault = (expOut == faultAddr);
            chk("outPc", out_pc, expOut);
            chk("outInst", out_inst, expFault ? 32'h0 : memWord(expOut));
            chk("outFault", out_fault, expFault);
            expOut += 4;
            pending--;
            outCnt++;
            if (expFault) halted = 1'b1;
        end
    endtask

    task automatic setRates(input int rd, input int rs, input int o);
        rdyPct = rd;
        rspPct = rs;
        outPct = o;
    endtask

    int mark;

    initial begin
        rst = 1'b0;
        idleInputs();
        faultAddr = NOFLT;
        outCnt = 0;
        setRates(100, 100, 100);
        modelReset(PC0);
        #12;
        chk("rstReqValid", imem_req_valid, 0);
        chk("rstReqAddr", imem_req_addr, PC0);
        chk("rstOutValid", out_valid, 0);
        chk("rstOutPc", out_pc, 0);
        chk("rstOutInst", out_inst, 0);
        chk("rstOutFault", out_fault, 0);
        @(posedge clk);
        #2 rst = 1'b1;

        // streaming from reset
        mark = outCnt;
        repeat (30) cycle(1'b0, '0);
        chk("streamProg", (outCnt - mark) >= 12, 1);

        // decoder stall fills exactly the credit pool
        setRates(100, 100, 0);
        repeat (10) cycle(1'b0, '0);
        chk("stallPend", pending, DEPTH);
        chk("stallReqOff", imem_req_valid, 0);
        chk("stallOutOn", out_valid, 1);
        setRates(100, 100, 100);
        mark = outCnt;
        repeat (20) cycle(1'b0, '0);
        chk("resumeProg", outCnt > mark, 1);

        // redirect with two requests in flight
        setRates(100, 0, 100);
        repeat (6) cycle(1'b0, '0);
        chk("inflight2", memQ.size(), 2);
        cycle(1'b1, 64'h8000_1000);
        setRates(100, 100, 100);
        mark = outCnt;
        repeat (12) cycle(1'b0, '0);
        chk("redir3Prog", outCnt > mark, 1);

        // redirect coinciding with a response
        setRates(100, 0, 100);
        repeat (6) cycle(1'b0, '0);
        chk("inflight2b", memQ.size(), 2);
        setRates(100, 100, 100);
        cycle(1'b1, 64'h8000_2000);
        mark = outCnt;
        repeat (12) cycle(1'b0, '0);
        chk("redir4Prog", outCnt > mark, 1);

        // async reset mid-burst, then fault at 80000008
        repeat (3) cycle(1'b0, '0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("midRstReq", imem_req_valid, 0);
        chk("midRstAddr", imem_req_addr, PC0);
        chk("midRstOut", out_valid, 0);
        chk("midRstPc", out_pc, 0);
        idleInputs();
        memQ.delete();
        modelReset(PC0);
        faultAddr = 64'h8000_0008;
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (15) cycle(1'b0, '0);
        chk("faultSeen", halted, 1);
        chk("faultCount", outCnt - mark >= 3, 1);
        cycle(1'b1, 64'h8000_0100);
        mark = outCnt;
        repeat (15) cycle(1'b0, '0);
        chk("faultResume", outCnt > mark, 1);

        // randomized segments
        for (int seg = 0; seg < 40; seg++) begin
            setRates($urandom_range(30, 100), $urandom_range(30, 100),
                     $urandom_range(20, 100));
            if ($urandom_range(2) == 0)
                faultAddr = PC0 + 64'(4 * $urandom_range(0, 60));
            else
                faultAddr = NOFLT;
            cycle(1'b1, PC0 + 64'(4 * $urandom_range(0, 40)));
            repeat (20) begin
                if ($urandom_range(99) < 4)
                    cycle(1'b1, PC0 + 64'(4 * $urandom_range(0, 40)));
                else
                    cycle(1'b0, '0);
            end
        end

        // final drain
        faultAddr = NOFLT;
        setRates(100, 100, 100);
        cycle(1'b1, 64'h8000_3000);
        mark = outCnt;
        repeat (20) cycle(1'b0, '0);
        chk("drainProg", outCnt > mark, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
